// File: rtl/percep_pkg.sv
// Shared types for the perceptron branch-predictor training path.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// Contents:
//   PERCEP_HIST    - default GHR snapshot width used by the predictor.
//   train_entry_t  - one resolved branch: {pc, taken, ghr}.
//   tsched_state_e - training scheduler FSM states.
package percep_pkg;

    localparam int PERCEP_HIST = 28;

    typedef struct packed {
        logic [31:0]            pc;
        logic                   taken;
        logic [PERCEP_HIST-1:0] ghr;
    } train_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } tsched_state_e;

endpackage

// File: rtl/percep_train_fifo.sv
// Synchronous FIFO of a packed entry type; the head is visible combinationally on pop_data.
// Latency: a pushed entry is poppable the cycle after the push.
// Backpressure: a push is accepted when not full, or when full and popping in the same cycle.
//
// Ports:
//   clk, rst             - clock, asynchronous active-high reset (pointers/occupancy only)
//   push, push_data      - write request and data at the tail
//   pop, pop_data        - consume request and current head entry
//   full, empty, count   - occupancy status; count is $clog2(DEPTH)+1 bits
module percep_train_fifo
    import percep_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = train_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    output T                       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] occ;
    logic          do_push;
    logic          do_pop;

    assign empty = (occ == '0);
    assign full  = (occ == CW'(DEPTH));
    assign count = occ;

    assign do_pop  = pop && !empty;
    // When full, the slot being written is the one being read this cycle;
    // the read sees the old contents because the write lands at the edge.
    assign do_push = push && (!full || do_pop);

    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            occ <= occ + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/percep_train_sched.sv
// Buffers resolved branches and issues them one at a time to the perceptron train port.
// Latency: ex_branch in cycle N (empty FIFO, IDLE) presents train_valid in cycle N+1.
// Backpressure: train_ready stalls the presented request; the pipeline is never stalled, overflow drops and counts.
//
// Ports:
//   clk, rst                          - clock, asynchronous active-high reset
//   ex_branch, ex_pc, ex_taken, ex_ghr - branch resolution from EX
//   gap_cfg                           - idle cycles forced after each accepted train (0..3)
//   hold                              - suspends new issue; queued entries retained
//   train_valid/pc/taken/ghr, train_ready - registered request to the perceptron
//   busy                              - queue non-empty or FSM not idle (registered)
//   train_cnt                         - accepted trains, wraps
//   drop_cnt                          - dropped resolutions, saturates
module percep_train_sched
    import percep_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int HIST  = 28,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_branch,
    input  logic [31:0]      ex_pc,
    input  logic             ex_taken,
    input  logic [HIST-1:0]  ex_ghr,
    input  logic [1:0]       gap_cfg,
    input  logic             hold,
    output logic             train_valid,
    output logic [31:0]      train_pc,
    output logic             train_taken,
    output logic [HIST-1:0]  train_ghr,
    input  logic             train_ready,
    output logic             busy,
    output logic [CNT_W-1:0] train_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;

    // Same layout as train_entry_t, but sized by this instance's HIST.
    typedef struct packed {
        logic [31:0]     pc;
        logic            taken;
        logic [HIST-1:0] ghr;
    } entry_t;

    entry_t        ex_entry;
    entry_t        head;
    entry_t        out_entry;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_nxt;

    tsched_state_e state;
    tsched_state_e state_nxt;
    logic [1:0]    gap_cnt;
    logic [1:0]    gap_cnt_nxt;

    logic          handshake;
    logic          issue_slot;
    logic          pop;
    logic          bypass;
    logic          load_out;
    logic          push;
    logic          drop;

    assign ex_entry  = {ex_pc, ex_taken, ex_ghr};
    assign handshake = train_valid && train_ready;

    percep_train_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (ex_entry),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // issue_slot marks a cycle in which the IDLE issue rules apply: IDLE itself,
    // a gap-0 handshake, or the last GAP cycle. Letting the final GAP cycle issue
    // makes the handshake spacing exactly gap_cfg+1 cycles.
    always_comb begin
        state_nxt   = state;
        gap_cnt_nxt = gap_cnt;
        issue_slot  = 1'b0;

        case (state)
            IDLE: begin
                issue_slot = 1'b1;
            end
            ISSUE: begin
                // hold is ignored here: a presented request is never withdrawn.
                if (handshake) begin
                    if (gap_cfg != 2'd0) begin
                        state_nxt   = GAP;
                        gap_cnt_nxt = gap_cfg - 2'd1;
                    end else begin
                        state_nxt  = IDLE;
                        issue_slot = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == 2'd0) begin
                    state_nxt  = IDLE;
                    issue_slot = 1'b1;
                end else begin
                    gap_cnt_nxt = gap_cnt - 2'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // With an empty queue the incoming branch goes straight to the output
        // register, giving single-cycle latency without a combinational path.
        pop      = issue_slot && !hold && !fifo_empty;
        bypass   = issue_slot && !hold && fifo_empty && ex_branch;
        load_out = pop || bypass;
        if (load_out) begin
            state_nxt = ISSUE;
        end

        push = ex_branch && !bypass && (!fifo_full || pop);
        drop = ex_branch && !bypass && !push;

        out_entry = pop ? head : ex_entry;
        count_nxt = fifo_count + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            gap_cnt     <= 2'd0;
            train_valid <= 1'b0;
            train_pc    <= '0;
            train_taken <= 1'b0;
            train_ghr   <= '0;
            busy        <= 1'b0;
            train_cnt   <= '0;
            drop_cnt    <= '0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_cnt_nxt;

            if (load_out) begin
                train_valid <= 1'b1;
                train_pc    <= out_entry.pc;
                train_taken <= out_entry.taken;
                train_ghr   <= out_entry.ghr;
            end else if (handshake) begin
                train_valid <= 1'b0;
            end

            if (handshake) begin
                train_cnt <= train_cnt + CNT_W'(1);
            end

            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end

            busy <= (count_nxt != '0) || (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_percep_train_sched.sv
`timescale 1ns/1ps
module tb_percep_train_sched;

    localparam int DEPTH = 4;
    localparam int HIST  = 28;
    localparam int CNT_W = 16;
    localparam int EW    = 33 + HIST;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ex_branch;
    logic [31:0]      ex_pc;
    logic             ex_taken;
    logic [HIST-1:0]  ex_ghr;
    logic [1:0]       gap_cfg;
    logic             hold;
    logic             train_valid;
    logic [31:0]      train_pc;
    logic             train_taken;
    logic [HIST-1:0]  train_ghr;
    logic             train_ready;
    logic             busy;
    logic [CNT_W-1:0] train_cnt;
    logic [CNT_W-1:0] drop_cnt;

    percep_train_sched #(.DEPTH(DEPTH), .HIST(HIST), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .ex_branch   (ex_branch),
        .ex_pc       (ex_pc),
        .ex_taken    (ex_taken),
        .ex_ghr      (ex_ghr),
        .gap_cfg     (gap_cfg),
        .hold        (hold),
        .train_valid (train_valid),
        .train_pc    (train_pc),
        .train_taken (train_taken),
        .train_ghr   (train_ghr),
        .train_ready (train_ready),
        .busy        (busy),
        .train_cnt   (train_cnt),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] obs_pc  [$];
    int          obs_cyc [$];

    task automatic idle_inputs();
        ex_branch   = 1'b0;
        ex_pc       = '0;
        ex_taken    = 1'b0;
        ex_ghr      = '0;
        gap_cfg     = 2'd0;
        hold        = 1'b0;
        train_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One branch resolution, presented for exactly one clock edge.
    task automatic send(input logic [31:0] pc, input logic tk, input logic [HIST-1:0] g);
        ex_branch = 1'b1;
        ex_pc     = pc;
        ex_taken  = tk;
        ex_ghr    = g;
        @(negedge clk);
        ex_branch = 1'b0;
    endtask

    // Records handshakes (pc and cycle) until n are seen or the budget expires.
    task automatic collect(input int n, input int budget);
        obs_pc.delete();
        obs_cyc.delete();
        for (int i = 0; i < budget && obs_pc.size() < n; i++) begin
            if (train_valid && train_ready) begin
                obs_pc.push_back(train_pc);
                obs_cyc.push_back(cyc);
            end
            @(negedge clk);
            ex_branch = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (train_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b need 0", train_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b need 0", busy); end
        n_checks++; if ({train_pc, train_taken, train_ghr} !== '0) begin n_fail++; $display("FAIL reset_fields: got %h/%b/%h need 0", train_pc, train_taken, train_ghr); end
        n_checks++; if (train_cnt !== '0 || drop_cnt !== '0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d need 0/0", train_cnt, drop_cnt); end
    endtask

    task automatic test_single();
        do_reset();
        train_ready = 1'b1;
        ex_branch = 1'b1; ex_pc = 32'h0000_1004; ex_taken = 1'b1; ex_ghr = 28'hA5A5A5A;
        @(negedge clk);
        ex_branch = 1'b0;
        n_checks++; if (train_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency: valid %b need 1", train_valid); end
        n_checks++; if (train_pc !== 32'h0000_1004 || train_taken !== 1'b1 || train_ghr !== 28'hA5A5A5A)
            begin n_fail++; $display("FAIL single_fields: got %h/%b/%h need 00001004/1/a5a5a5a", train_pc, train_taken, train_ghr); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_on: got %b need 1", busy); end
        @(negedge clk);
        n_checks++; if (train_cnt !== 16'd1) begin n_fail++; $display("FAIL single_cnt: got %0d need 1", train_cnt); end
        n_checks++; if (train_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: valid %b busy %b need 0 0", train_valid, busy); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 6; i++) send(32'h100 + i * 4, i[0], HIST'($urandom()));
        n_checks++; if (drop_cnt !== 16'd1) begin n_fail++; $display("FAIL ovf_drop: got %0d need 1", drop_cnt); end
        n_checks++; if (train_valid !== 1'b1 || train_pc !== 32'h100) begin n_fail++; $display("FAIL ovf_head: valid %b pc %h need 1 100", train_valid, train_pc); end
        train_ready = 1'b1;
        collect(6, 20);
        n_checks++; if (obs_pc.size() != 5) begin n_fail++; $display("FAIL ovf_count: got %0d need 5", obs_pc.size()); end
        for (int i = 0; i < obs_pc.size() && i < 5; i++) begin
            n_checks++; if (obs_pc[i] !== 32'h100 + i * 4) begin n_fail++; $display("FAIL ovf_order[%0d]: got %h need %h", i, obs_pc[i], 32'h100 + i * 4); end
        end
        n_checks++; if (train_cnt !== 16'd5 || drop_cnt !== 16'd1) begin n_fail++; $display("FAIL ovf_counters: got %0d/%0d need 5/1", train_cnt, drop_cnt); end
    endtask

    task automatic test_full_dequeue();
        logic [31:0] exp_pc [6];
        do_reset();
        for (int i = 0; i < 5; i++) begin
            exp_pc[i] = 32'h200 + i * 4;
            send(exp_pc[i], 1'b0, HIST'($urandom()));
        end
        exp_pc[5] = 32'h2FC;
        ex_branch = 1'b1; ex_pc = exp_pc[5]; ex_taken = 1'b1; ex_ghr = '0;
        train_ready = 1'b1;
        collect(6, 20);
        n_checks++; if (obs_pc.size() != 6) begin n_fail++; $display("FAIL fulldq_count: got %0d need 6", obs_pc.size()); end
        for (int i = 0; i < obs_pc.size() && i < 6; i++) begin
            n_checks++; if (obs_pc[i] !== exp_pc[i]) begin n_fail++; $display("FAIL fulldq_order[%0d]: got %h need %h", i, obs_pc[i], exp_pc[i]); end
        end
        n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL fulldq_drop: got %0d need 0", drop_cnt); end
    endtask

    task automatic test_gap();
        for (int g = 0; g < 4; g++) begin
            do_reset();
            gap_cfg = 2'(g);
            for (int i = 0; i < 3; i++) send(32'h500 + i * 4, 1'b1, HIST'(i));
            train_ready = 1'b1;
            collect(3, 40);
            n_checks++; if (obs_pc.size() != 3) begin n_fail++; $display("FAIL gap%0d_count: got %0d need 3", g, obs_pc.size()); end
            for (int k = 1; k < obs_pc.size(); k++) begin
                n_checks++; if (obs_cyc[k] - obs_cyc[k-1] != g + 1)
                    begin n_fail++; $display("FAIL gap%0d_spacing[%0d]: got %0d need %0d", g, k, obs_cyc[k] - obs_cyc[k-1], g + 1); end
                n_checks++; if (obs_pc[k] !== 32'h500 + k * 4)
                    begin n_fail++; $display("FAIL gap%0d_order[%0d]: got %h need %h", g, k, obs_pc[k], 32'h500 + k * 4); end
            end
        end
    endtask

    task automatic test_hold();
        do_reset();
        for (int i = 0; i < 3; i++) send(32'h300 + i * 4, 1'b0, HIST'(i));
        hold = 1'b1;
        train_ready = 1'b1;
        collect(3, 8);
        n_checks++; if (obs_pc.size() != 1 || obs_pc[0] !== 32'h300) begin n_fail++; $display("FAIL hold_single: got %0d trains need 1 (pc 300)", obs_pc.size()); end
        n_checks++; if (train_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL hold_parked: valid %b busy %b need 0 1", train_valid, busy); end
        hold = 1'b0;
        collect(2, 10);
        n_checks++; if (obs_pc.size() != 2 || obs_pc[0] !== 32'h304 || obs_pc[1] !== 32'h308)
            begin n_fail++; $display("FAIL hold_drain: got %0d trains need 2 (304,308)", obs_pc.size()); end
        n_checks++; if (train_cnt !== 16'd3 || busy !== 1'b0) begin n_fail++; $display("FAIL hold_final: cnt %0d busy %b need 3 0", train_cnt, busy); end
    endtask

    task automatic test_async_reset();
        do_reset();
        train_ready = 1'b1;
        send(32'h3F0, 1'b1, '1);
        @(negedge clk);
        train_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(32'h400 + i * 4, 1'b1, '1);
        n_checks++; if (train_valid !== 1'b1 || train_cnt !== 16'd1) begin n_fail++; $display("FAIL arst_pre: valid %b cnt %0d need 1 1", train_valid, train_cnt); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (train_valid !== 1'b0 || busy !== 1'b0 || train_cnt !== '0 || drop_cnt !== '0)
            begin n_fail++; $display("FAIL arst_immediate: valid %b busy %b cnt %0d drop %0d need all 0", train_valid, busy, train_cnt, drop_cnt); end
        n_checks++; if ({train_pc, train_taken, train_ghr} !== '0) begin n_fail++; $display("FAIL arst_fields: got %h/%b/%h need 0", train_pc, train_taken, train_ghr); end
        @(negedge clk);
        rst = 1'b0;
        train_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (train_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL arst_empty: valid %b busy %b need 0 0", train_valid, busy); end
    endtask

    // Random traffic. Reference: every resolution goes into an ordered list;
    // each handshake must be the earliest remaining entry after discarding
    // those the scheduler dropped, so the discards must equal drop_cnt.
    task automatic test_random();
        logic [EW-1:0] sent [$];
        logic [EW-1:0] cur;
        logic [EW-1:0] stall_val;
        logic          stall;
        int            skipped;
        int            hs;
        int            last_hs;
        int            last_gap;
        int            uid;
        do_reset();
        stall = 1'b0; stall_val = '0;
        skipped = 0; hs = 0; last_hs = -100; last_gap = 0; uid = 1;
        for (int c = 0; c < 3100; c++) begin
            cur = {train_pc, train_taken, train_ghr};
            if (stall) begin
                n_checks++;
                if (train_valid !== 1'b1 || cur !== stall_val)
                    begin n_fail++; $display("FAIL rand_stable: cycle %0d valid %b entry %h need 1 %h", cyc, train_valid, cur, stall_val); end
            end
            if (c < 3000) begin
                ex_branch   = ($urandom_range(0, 99) < 55);
                train_ready = ($urandom_range(0, 99) < 45);
                hold        = ($urandom_range(0, 99) < 8);
                if ($urandom_range(0, 49) == 0) gap_cfg = 2'($urandom_range(0, 3));
            end else begin
                ex_branch = 1'b0; train_ready = 1'b1; hold = 1'b0;
            end
            if (ex_branch) begin
                ex_pc    = {uid[29:0], 2'b00};
                ex_taken = 1'($urandom());
                ex_ghr   = HIST'($urandom());
                sent.push_back({ex_pc, ex_taken, ex_ghr});
                uid++;
            end
            if (train_valid && train_ready) begin
                while (sent.size() > 0 && sent[0] !== cur) begin
                    void'(sent.pop_front());
                    skipped++;
                end
                n_checks++;
                if (sent.size() == 0) begin n_fail++; $display("FAIL rand_order: cycle %0d trained %h not pending in order", cyc, cur); end
                else void'(sent.pop_front());
                n_checks++;
                if (cyc - last_hs < last_gap + 1)
                    begin n_fail++; $display("FAIL rand_spacing: got %0d cycles need >= %0d", cyc - last_hs, last_gap + 1); end
                hs++;
                last_hs  = cyc;
                last_gap = int'(gap_cfg);
            end
            stall     = train_valid && !train_ready;
            stall_val = cur;
            @(negedge clk);
        end
        n_checks++; if (train_cnt !== CNT_W'(hs)) begin n_fail++; $display("FAIL rand_train_cnt: got %0d need %0d", train_cnt, hs); end
        n_checks++; if (drop_cnt !== CNT_W'(skipped + sent.size()))
            begin n_fail++; $display("FAIL rand_drop_cnt: got %0d need %0d", drop_cnt, skipped + sent.size()); end
        n_checks++; if (busy !== 1'b0 || train_valid !== 1'b0) begin n_fail++; $display("FAIL rand_drained: busy %b valid %b need 0 0", busy, train_valid); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_overflow();
        test_full_dequeue();
        test_gap();
        test_hold();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/percep_train_sched.md
# percep_train_sched

Training scheduler for the perceptron branch predictor. It sits between the EX-stage branch-resolution outputs (`exBranch`, `exPc`, `exTaken`, GHR snapshot) and the perceptron's train port. Resolved branches are buffered in a small FIFO and issued one at a time over a valid/ready handshake. A programmable gap separates successive updates so the perceptron's read-modify-write of weights never overlaps. Training is non-architectural, so the block never stalls the pipeline: on overflow it drops the entry and counts the drop.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries; power of two, at least 2.
- `HIST`, default 28: GHR snapshot width; matches the perceptron's `HIST`.
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `clk`, input, 1: the single clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `ex_branch`, input, 1: a branch resolved in EX this cycle.
- `ex_pc`, input, 32: PC of the resolved branch.
- `ex_taken`, input, 1: resolved direction.
- `ex_ghr`, input, HIST: GHR snapshot captured at prediction time.
- `gap_cfg`, input, 2: idle cycles forced after each accepted train (0–3).
- `hold`, input, 1: suspends new issue; queued entries are retained.
- `train_valid`, output, 1: a training request is presented.
- `train_pc`, output, 32: PC of the request.
- `train_taken`, output, 1: direction of the request.
- `train_ghr`, output, HIST: GHR of the request.
- `train_ready`, input, 1: the perceptron accepts the request.
- `busy`, output, 1: FIFO non-empty or FSM not in IDLE.
- `train_cnt`, output, CNT_W: accepted trains; wraps.
- `drop_cnt`, output, CNT_W: dropped resolutions; saturates at all-ones.

## Operation
- **Enqueue.** When `ex_branch` = 1, {`ex_pc`, `ex_taken`, `ex_ghr`} is written at the tail.
  - The write is accepted if occupancy < DEPTH.
  - It is also accepted if occupancy = DEPTH and a dequeue occurs in the same cycle.
  - Otherwise the entry is discarded and `drop_cnt` increments (saturating).
- **FSM states:** IDLE, ISSUE, GAP.
  - IDLE → ISSUE when the FIFO is non-empty and `hold` = 0. The head entry is popped into the output registers and `train_valid` is set.
  - ISSUE stays in ISSUE while `train_ready` = 0. `train_*` outputs hold stable and `hold` is ignored, because a presented request is never withdrawn.
  - ISSUE → on `train_valid && train_ready`, `train_cnt` increments. The next state is GAP with the gap counter loaded to `gap_cfg`−1 if `gap_cfg` ≠ 0. If `gap_cfg` = 0, the next state follows IDLE rules in the same cycle, allowing back-to-back issue.
  - GAP counts down to 0, then goes to IDLE. `gap_cfg` is sampled only on the handshake.
- **Ordering:** strictly FIFO. Training order equals resolution order.
- **Width rules:**
  - Occupancy counter is $clog2(DEPTH)+1 bits.
  - Read/write pointers are $clog2(DEPTH) bits and wrap naturally.
  - `train_cnt` wraps modulo 2^CNT_W.

## Timing
- **Reset values:**
  - `train_valid`, `busy`: 0.
  - `train_pc`, `train_taken`, `train_ghr`: 0.
  - `train_cnt`, `drop_cnt`: 0.
  - FSM: IDLE. FIFO: empty.
- **Latency:** with an empty FIFO and IDLE state, `ex_branch` in cycle N gives `train_valid` = 1 in cycle N+1. No combinational path exists from `ex_*` to `train_*`.
- **Throughput:**
  - `gap_cfg` = 0: one train per cycle while `train_ready` = 1.
  - `gap_cfg` = g: one train per g+1 cycles.
- **Outputs:** all are registered. `busy` is registered from next-state occupancy and FSM state.
- **Reset mid-handshake:** outputs clear immediately; queued entries are lost. The perceptron must tolerate `train_valid` falling without a handshake.

## Structure
- Package `percep_pkg` holds:
  - `train_entry_t`, a packed struct {pc[31:0], taken, ghr[HIST-1:0]}.
  - The FSM enum `tsched_state_e` {IDLE, ISSUE, GAP}.
- Sub-module `percep_train_fifo`: parameterised sync FIFO of `train_entry_t` with push, pop, full, empty and count. It is reusable for the fetch-side request queue.
- Top level holds the FSM, gap counter, output registers and statistics counters.

## Test plan
- **Single branch:** reset, then `ex_branch` with pc=0x0000_1004, taken=1, ghr=0xA5A5A5A, `train_ready`=1. Expect `train_valid` one cycle later with matching fields, `train_cnt`=1, then `busy`=0.
- **Overflow:** DEPTH=4, `train_ready`=0, six consecutive branches. Expect 5 held (4 in FIFO plus 1 in the output register), `drop_cnt`=1. After release, pcs issue in order.
- **Full plus simultaneous dequeue:** FIFO full, output accepted in the same cycle as a new `ex_branch`. Expect no drop and the new entry trained last.
- **Gap:** `gap_cfg`=2, three queued branches, `train_ready`=1. Expect `train_valid` handshakes exactly 3 cycles apart. With `gap_cfg`=0, expect back-to-back handshakes.
- **Hold:** assert `hold` while in ISSUE. Expect the current request completes, no new issue while `hold`=1, and the FIFO is retained and drains after release.
- **Async reset:** assert `rst` between clock edges while `train_valid`=1 and 3 entries are queued. Expect all outputs and counters 0 immediately and an empty FIFO after release.
